axi_slave_mem: RTL and testbench
================================

Name: axi_slave_mem

Overview:
- AXI3 responder (slave) with a word-addressed internal memory.
- Terminates the master-side driver's write-address, write-data, write-response, read-address and read-data channels.
- Used as the bench-side DUT endpoint and as a simple on-chip RAM target.
- Independent write and read engines, one outstanding burst each; reads and writes run concurrently.

Parameters:
MEM_DEPTH  1024  number of 32-bit words; power of two
BASE_ADDR  32'h0000_0000  byte address of word 0

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
AWID, ARID  in  4  burst ID (write / read)
AWADDR, ARADDR  in  32  start byte address
AWLEN, ARLEN  in  4  beats minus 1 (1..16 beats)
AWSIZE, ARSIZE  in  3  bytes per beat = 2^SIZE
AWBURST, ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
AWVALID, ARVALID  in  1  address valid
AWREADY, ARREADY  out  1  address accepted
WID  in  4  write data ID
WDATA  in  32  write data
WSTRB  in  4  byte-lane enables
WLAST  in  1  last write beat
WVALID  in  1  write data valid
WREADY  out  1  write data accepted
BID  out  4  response ID = captured AWID
BRESP  out  2  00 OKAY, 10 SLVERR
BVALID  out  1  response valid
BREADY  in  1  response accepted
RID  out  4  = captured ARID
RDATA  out  32  read data
RRESP  out  2  00 OKAY, 10 SLVERR
RLAST  out  1  last read beat
RVALID  out  1  read data valid
RREADY  in  1  read data accepted

Behaviour:
- Reset (rstn low, async):
  - All outputs 0; both FSMs go to IDLE.
  - Memory contents are not reset.
  - Reset mid-burst aborts the burst; no B/R completion is issued.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1 (registered; first high one cycle after rstn rises). On AWVALID&&AWREADY capture ID/ADDR/LEN/SIZE/BURST, clear beat counter and error flag, go W_DATA.
  - W_DATA: WREADY=1. Each WVALID&&WREADY beat writes the enabled byte lanes of the addressed word, then advances the address.
  - Burst ends on beat LEN+1 regardless of WLAST, then W_RESP.
  - W_RESP: BVALID=1, BID=captured ID. Hold until BREADY, then W_IDLE; AWREADY is high the next cycle.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On handshake capture fields; go R_DATA.
  - R_DATA: RVALID rises the cycle after the AR handshake; RDATA is registered from memory when the beat is loaded.
  - RID, RDATA, RRESP and RLAST are held stable while RVALID&&!RREADY.
  - On RVALID&&RREADY, load the next beat in the next cycle (back-to-back, no bubble).
  - RLAST=1 only on beat LEN. After the last handshake, return to R_IDLE with RVALID low.
- Address update per beat (incr = 2^SIZE):
  - FIXED: address unchanged.
  - INCR: addr += incr, 32-bit wrap.
  - WRAP: boundary = (LEN+1)*incr; addr = (addr & ~(boundary-1)) | ((addr+incr) & (boundary-1)).
- Word index = (addr - BASE_ADDR) >> 2. A beat is out of range if addr < BASE_ADDR or index >= MEM_DEPTH.
- Error conditions (SLVERR):
  - Write response is SLVERR if any of: SIZE>2; BURST=11; WRAP with LEN not in {1,3,7,15}; any beat out of range; WID != captured AWID; WLAST mismatch (set before final beat, or clear on final beat). Otherwise OKAY.
  - Write beats with SIZE>2, BURST=11 or an out-of-range address are dropped (no memory write). Other beats are written normally.
  - Read beats under the same address/size/burst conditions return RDATA=0 and RRESP=10. All other read beats return OKAY.
- Same-cycle read load and write to the same word: read returns the old data.
- AWLOCK/AWCACHE/AWPROT and AR equivalents are not ported and are ignored.

Test Plan:
- Reset then AW INCR addr 0x10, LEN=3, SIZE=2, 4 beats 0xA0..0xA3 with WSTRB=F -> BVALID one cycle after the last beat, BRESP=00, BID=AWID; AR same address -> RDATA A0..A3, RLAST on beat 4, RRESP=00.
- Write 0x11223344 to 0x40 with WSTRB=0101 over 0xFFFFFFFF -> read 0x40 returns 0xFF22FF44.
- WRAP LEN=3 SIZE=2 at 0x38 -> beats at 0x38, 0x3C, 0x30, 0x34; FIXED LEN=2 at 0x50 -> three writes to 0x50, last value wins.
- Write at BASE_ADDR+MEM_DEPTH*4 -> BRESP=10, memory unchanged; read there -> RDATA=0, RRESP=10; WID!=AWID on an in-range burst -> BRESP=10.
- RREADY toggled 1/0 during LEN=7 read -> RDATA held while stalled; 8 handshakes total; RLAST only on the 8th. BREADY held low 5 cycles -> BVALID held, AWREADY stays 0.
- Deassert rstn during W_DATA beat 2 -> all outputs 0 immediately; after release AWREADY=1, ARREADY=1 and a new burst completes OKAY.

Source files
------------

// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - AXI3 responder with word-addressed internal RAM
// Independent write and read engines, one outstanding burst each.
module axi_slave_mem #(
  parameter int          MEM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  AWID,
  input  logic [31:0] AWADDR,
  input  logic [3:0]  AWLEN,
  input  logic [2:0]  AWSIZE,
  input  logic [1:0]  AWBURST,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [3:0]  WID,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WLAST,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [3:0]  BID,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic [3:0]  ARID,
  input  logic [31:0] ARADDR,
  input  logic [3:0]  ARLEN,
  input  logic [2:0]  ARSIZE,
  input  logic [1:0]  ARBURST,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [3:0]  RID,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RLAST,
  output logic        RVALID,
  input  logic        RREADY
);
  localparam int          AW      = $clog2(MEM_DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  logic [31:0] r_mem [MEM_DEPTH];

  function automatic logic [31:0] f_next_addr(input logic [31:0] addr, input logic [3:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] incr;
    logic [31:0] mask;
    incr = 32'd1 << size;
    mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      2'b00:   f_next_addr = addr;
      2'b10:   f_next_addr = (addr & ~mask) | ((addr + incr) & mask);
      default: f_next_addr = addr + incr;
    endcase
  endfunction

  function automatic logic f_in_range(input logic [31:0] addr);
    f_in_range = (addr >= BASE_ADDR) && (((addr - BASE_ADDR) >> 2) < DEPTH_W);
  endfunction

  function automatic logic [AW-1:0] f_index(input logic [31:0] addr);
    f_index = AW'((addr - BASE_ADDR) >> 2);
  endfunction

  w_state_t    r_wstate, w_wstate_nxt;
  logic        r_awready, r_wready, r_bvalid, r_werr;
  logic [3:0]  r_awid, r_awlen, r_wbeat;
  logic [2:0]  r_awsize;
  logic [1:0]  r_awburst;
  logic [31:0] r_waddr;
  logic        w_aw_hs, w_w_hs, w_wlast_beat, w_wdrop;

  assign w_aw_hs      = AWVALID && r_awready;
  assign w_w_hs       = WVALID && r_wready;
  assign w_wlast_beat = (r_wbeat == r_awlen);
  assign w_wdrop      = (r_awsize > 3'd2) || (r_awburst == 2'b11) || !f_in_range(r_waddr);

  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BID     = r_awid;
  assign BRESP   = {r_werr, 1'b0};

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_hs && w_wlast_beat) w_wstate_nxt = W_RESP;
      W_RESP:  if (r_bvalid && BREADY) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they drop to 0 in reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE);
      r_wready  <= (w_wstate_nxt == W_DATA);
      r_bvalid  <= (w_wstate_nxt == W_RESP);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_awid    <= 4'd0;
      r_awlen   <= 4'd0;
      r_awsize  <= 3'd0;
      r_awburst <= 2'd0;
      r_waddr   <= 32'd0;
      r_wbeat   <= 4'd0;
      r_werr    <= 1'b0;
    end else if (w_aw_hs) begin
      r_awid    <= AWID;
      r_awlen   <= AWLEN;
      r_awsize  <= AWSIZE;
      r_awburst <= AWBURST;
      r_waddr   <= AWADDR;
      r_wbeat   <= 4'd0;
      r_werr    <= (AWSIZE > 3'd2) || (AWBURST == 2'b11) ||
                   ((AWBURST == 2'b10) && !((AWLEN == 4'd1) || (AWLEN == 4'd3) ||
                                            (AWLEN == 4'd7) || (AWLEN == 4'd15)));
    end else if (w_w_hs) begin
      r_waddr <= f_next_addr(r_waddr, r_awlen, r_awsize, r_awburst);
      r_wbeat <= r_wbeat + 4'd1;
      if (w_wdrop || (WID != r_awid) || (WLAST != w_wlast_beat))
        r_werr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_w_hs && !w_wdrop) begin
      for (int b = 0; b < 4; b++)
        if (WSTRB[b]) r_mem[f_index(r_waddr)][8*b +: 8] <= WDATA[8*b +: 8];
    end
  end

  r_state_t    r_rstate, w_rstate_nxt;
  logic        r_arready, r_rvalid, r_rlast;
  logic [3:0]  r_arid, r_arlen, r_rbeat;
  logic [2:0]  r_arsize;
  logic [1:0]  r_arburst;
  logic [31:0] r_raddr, r_rdata;
  logic [1:0]  r_rresp;
  logic        w_ar_hs, w_r_hs, w_rload, w_ld_ok;
  logic [31:0] w_ld_addr;
  logic [3:0]  w_ld_len, w_ld_beat;
  logic [2:0]  w_ld_size;
  logic [1:0]  w_ld_burst;

  assign w_ar_hs = ARVALID && r_arready;
  assign w_r_hs  = r_rvalid && RREADY;
  assign w_rload = w_ar_hs || (w_r_hs && !r_rlast);

  // Beat 0 is loaded straight from the AR channel so RVALID follows the handshake by one cycle.
  assign w_ld_addr  = (r_rstate == R_IDLE) ? ARADDR  : r_raddr;
  assign w_ld_len   = (r_rstate == R_IDLE) ? ARLEN   : r_arlen;
  assign w_ld_size  = (r_rstate == R_IDLE) ? ARSIZE  : r_arsize;
  assign w_ld_burst = (r_rstate == R_IDLE) ? ARBURST : r_arburst;
  assign w_ld_beat  = (r_rstate == R_IDLE) ? 4'd0    : r_rbeat + 4'd1;
  assign w_ld_ok    = (w_ld_size <= 3'd2) && (w_ld_burst != 2'b11) && f_in_range(w_ld_addr);

  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RID     = r_arid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;
  assign RLAST   = r_rlast;

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_arid    <= 4'd0;
      r_arlen   <= 4'd0;
      r_arsize  <= 3'd0;
      r_arburst <= 2'd0;
      r_raddr   <= 32'd0;
      r_rbeat   <= 4'd0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= 32'd0;
      r_rresp   <= 2'd0;
    end else begin
      if (w_ar_hs) begin
        r_arid    <= ARID;
        r_arlen   <= ARLEN;
        r_arsize  <= ARSIZE;
        r_arburst <= ARBURST;
      end
      if (w_rload) begin
        r_rvalid <= 1'b1;
        r_rbeat  <= w_ld_beat;
        r_rlast  <= (w_ld_beat == w_ld_len);
        r_raddr  <= f_next_addr(w_ld_addr, w_ld_len, w_ld_size, w_ld_burst);
        r_rdata  <= w_ld_ok ? r_mem[f_index(w_ld_addr)] : 32'd0;
        r_rresp  <= w_ld_ok ? 2'b00 : 2'b10;
      end else if (w_r_hs) begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb/tb_axi_slave_mem.sv - self-checking bench for axi_slave_mem
// Reference memory and burst address rules are modelled with plain arithmetic on an array.
module tb_axi_slave_mem;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0, rstn = 1'b0;
  logic [3:0]  AWID, ARID, WID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  AWLEN, ARLEN, WSTRB;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  axi_slave_mem #(.MEM_DEPTH(DEPTH), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rstn(rstn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  int          n_checks = 0, n_errors = 0;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [3:0]  wr_id, wr_len, wr_beat;
  logic [2:0]  wr_size;
  logic [1:0]  wr_burst, last_bresp;
  logic [31:0] wr_addr, rd;
  logic        wr_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_next(input logic [31:0] addr, input logic [3:0] len,
                                         input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] incr, bnd;
    incr = 32'd1 << size;
    bnd  = (32'(len) + 32'd1) * incr;
    if (burst == 2'b00)      m_next = addr;
    else if (burst == 2'b10) m_next = (addr & ~(bnd - 1)) | ((addr + incr) & (bnd - 1));
    else                     m_next = addr + incr;
  endfunction

  function automatic logic m_ok(input logic [31:0] addr, input logic [2:0] size, input logic [1:0] burst);
    m_ok = (size <= 3'd2) && (burst != 2'b11) && ((addr >> 2) < 32'(DEPTH));
  endfunction

  function automatic logic [63:0] outs();
    outs = 64'({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RDATA, RRESP, RLAST});
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    wr_id = id; wr_addr = addr; wr_len = len; wr_size = size; wr_burst = burst; wr_beat = 0;
    wr_err = (size > 3'd2) || (burst == 2'b11) ||
             ((burst == 2'b10) && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    while (AWREADY !== 1'b1 && n < 100) begin cyc(); n++; end
    if (n >= 100) check("aw_timeout", 0, 1);
    cyc();
    AWVALID = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic [3:0] wid,
                        input logic last);
    int n = 0;
    WDATA = data; WSTRB = strb; WID = wid; WLAST = last; WVALID = 1'b1;
    while (WREADY !== 1'b1 && n < 100) begin cyc(); n++; end
    if (n >= 100) check("w_timeout", 0, 1);
    cyc();
    WVALID = 1'b0; WLAST = 1'b0;
    if (!m_ok(wr_addr, wr_size, wr_burst)) wr_err = 1'b1;
    else for (int b = 0; b < 4; b++)
      if (strb[b]) m_mem[int'(wr_addr >> 2)][8*b +: 8] = data[8*b +: 8];
    if (wid != wr_id) wr_err = 1'b1;
    if (last != (wr_beat == wr_len)) wr_err = 1'b1;
    wr_addr = m_next(wr_addr, wr_len, wr_size, wr_burst);
    wr_beat++;
  endtask

  task automatic b_collect(input int delay);
    int n = 0;
    while (BVALID !== 1'b1 && n < 100) begin cyc(); n++; end
    if (n >= 100) check("b_timeout", 0, 1);
    for (int i = 0; i < delay; i++) begin
      cyc();
      check("b_hold", {BVALID, AWREADY}, 2'b10);
    end
    check("bid", BID, wr_id);
    check("bresp", BRESP, {wr_err, 1'b0});
    last_bresp = BRESP;
    BREADY = 1'b1;
    cyc();
    BREADY = 1'b0;
    check("b_done", {BVALID, AWREADY}, 2'b01);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] wid,
                          input logic wlast_err, input int delay);
    aw_send(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++)
      w_beat(wbuf[i], sbuf[i], wid, (i == int'(len)) ^ (wlast_err && i == 0));
    check("bvalid_timing", BVALID, 1);
    b_collect(delay);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic toggle,
                         output logic [31:0] last_data);
    logic [31:0] a, ed [16];
    logic [1:0]  er [16];
    logic [63:0] hold;
    int          n;
    a = addr;
    last_data = 32'd0;
    for (int b = 0; b <= int'(len); b++) begin
      ed[b] = m_ok(a, size, burst) ? m_mem[int'(a >> 2)] : 32'd0;
      er[b] = m_ok(a, size, burst) ? 2'b00 : 2'b10;
      a = m_next(a, len, size, burst);
    end
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    n = 0;
    while (ARREADY !== 1'b1 && n < 100) begin cyc(); n++; end
    if (n >= 100) check("ar_timeout", 0, 1);
    cyc();
    ARVALID = 1'b0;
    check("rvalid_timing", RVALID, 1);
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (RVALID !== 1'b1 && n < 100) begin cyc(); n++; end
      if (n >= 100) check("r_timeout", 0, 1);
      if (toggle && b[0]) begin
        RREADY = 1'b0;
        hold = 64'({RID, RDATA, RRESP, RLAST, RVALID});
        cyc();
        check("r_hold", 64'({RID, RDATA, RRESP, RLAST, RVALID}), hold);
      end
      RREADY = 1'b1;
      check("rdata", RDATA, ed[b]);
      check("rresp", RRESP, er[b]);
      check("rlast", RLAST, b == int'(len));
      check("rid", RID, id);
      last_data = RDATA;
      cyc();
      RREADY = 1'b0;
    end
    check("r_done", {RVALID, ARREADY}, 2'b01);
  endtask

  initial begin
    logic [3:0]  id, len, wid;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] addr;
    {AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID} = '0;
    {ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID} = '0;
    {WID, WDATA, WSTRB, WLAST, WVALID, BREADY, RREADY} = '0;
    repeat (3) cyc();
    check("reset_outputs", outs(), 0);
    rstn = 1'b1;
    #1;
    check("ready_at_release", {AWREADY, ARREADY}, 2'b00);
    cyc();
    check("ready_after_reset", {AWREADY, ARREADY}, 2'b11);

    // Give every word a known value first.
    for (int k = 0; k < DEPTH / 16; k++) begin
      for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
      do_write(4'(k), 32'(k * 64), 4'd15, 3'd2, 2'b01, 4'(k), 1'b0, 0);
    end

    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    do_write(4'd5, 32'h10, 4'd3, 3'd2, 2'b01, 4'd5, 1'b0, 0);
    check("incr_bresp", last_bresp, 2'b00);
    do_read(4'd9, 32'h10, 4'd3, 3'd2, 2'b01, 1'b0, rd);
    check("incr_last", rd, 32'hA3);

    wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'hF;
    do_write(4'd1, 32'h40, 4'd0, 3'd2, 2'b01, 4'd1, 1'b0, 0);
    wbuf[0] = 32'h1122_3344; sbuf[0] = 4'b0101;
    do_write(4'd1, 32'h40, 4'd0, 3'd2, 2'b01, 4'd1, 1'b0, 0);
    do_read(4'd2, 32'h40, 4'd0, 3'd2, 2'b01, 1'b0, rd);
    check("strobe_merge", rd, 32'hFF22_FF44);

    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hB0 + 32'(i); sbuf[i] = 4'hF; end
    do_write(4'd2, 32'h38, 4'd3, 3'd2, 2'b10, 4'd2, 1'b0, 0);
    check("wrap_bresp", last_bresp, 2'b00);
    do_read(4'd3, 32'h30, 4'd3, 3'd2, 2'b01, 1'b0, rd);
    check("wrap_order", rd, 32'hB1);

    for (int i = 0; i < 3; i++) wbuf[i] = 32'hC0 + 32'(i);
    do_write(4'd4, 32'h50, 4'd2, 3'd2, 2'b00, 4'd4, 1'b0, 0);
    do_read(4'd4, 32'h50, 4'd0, 3'd2, 2'b01, 1'b0, rd);
    check("fixed_last_wins", rd, 32'hC2);

    wbuf[0] = 32'hDEAD_BEEF;
    do_write(4'd6, 32'(DEPTH * 4), 4'd0, 3'd2, 2'b01, 4'd6, 1'b0, 0);
    check("oor_bresp", last_bresp, 2'b10);
    do_read(4'd6, 32'(DEPTH * 4), 4'd0, 3'd2, 2'b01, 1'b0, rd);
    check("oor_rdata", rd, 32'h0);
    do_read(4'd6, 32'h0, 4'd0, 3'd2, 2'b01, 1'b0, rd);
    do_write(4'd6, 32'h60, 4'd1, 3'd2, 2'b01, 4'd7, 1'b0, 0);
    check("wid_bresp", last_bresp, 2'b10);

    do_read(4'd7, 32'h100, 4'd7, 3'd2, 2'b01, 1'b1, rd);
    do_write(4'd8, 32'h120, 4'd1, 3'd2, 2'b01, 4'd8, 1'b0, 5);

    // Reset lands while the third write beat is being presented.
    aw_send(4'd3, 32'h200, 4'd3, 3'd2, 2'b01);
    w_beat(32'hD0, 4'hF, 4'd3, 1'b0);
    w_beat(32'hD1, 4'hF, 4'd3, 1'b0);
    WDATA = 32'hD2; WVALID = 1'b1;
    rstn = 1'b0;
    #1;
    check("reset_midburst", outs(), 0);
    WVALID = 1'b0;
    cyc(); cyc();
    rstn = 1'b1;
    cyc();
    check("ready_after_midreset", {AWREADY, ARREADY}, 2'b11);
    do_read(4'd1, 32'h200, 4'd3, 3'd2, 2'b01, 1'b0, rd);
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hE0 + 32'(i); sbuf[i] = 4'hF; end
    do_write(4'd3, 32'h200, 4'd3, 3'd2, 2'b01, 4'd3, 1'b0, 0);
    check("post_reset_bresp", last_bresp, 2'b00);

    for (int it = 0; it < 80; it++) begin
      id    = 4'($urandom_range(0, 15));
      addr  = 32'($urandom_range(0, 32'h103F));
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      len   = 4'($urandom_range(0, 15));
      size  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      burst = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom_range(0, 15)); end
        wid = ($urandom_range(0, 7) == 0) ? id ^ 4'd1 : id;
        do_write(id, addr, len, size, burst, wid, $urandom_range(0, 7) == 0, $urandom_range(0, 2));
      end else begin
        do_read(id, addr, len, size, burst, 1'($urandom_range(0, 1)), rd);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
